// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker on the active-low lamp bus (phase order, dwell, good-cycle count).
// Optional: define TL_MON_TOL_EN to accept dwell within EXP +/- TOL (lower bound floored at 1).
module traffic_light_monitor #(
    parameter int RED_CYCLES   = 10,
    parameter int GREEN_CYCLES = 5,
    parameter int BLUE_CYCLES  = 3,
    parameter int CNT_W        = 8,
    parameter int TOL          = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       light,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic [7:0]       dwell,
    output logic             seq_err,
    output logic             dur_err,
    output logic             code_err,
    output logic             err_sticky,
    output logic             cycle_done,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [2:0] L_RED   = 3'b101;
    localparam logic [2:0] L_GREEN = 3'b110;
    localparam logic [2:0] L_BLUE  = 3'b011;
    localparam logic [2:0] L_DARK  = 3'b111;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        RED   = 2'd1,
        GREEN = 2'd2,
        BLUE  = 2'd3
    } phase_t;

`ifdef TL_MON_TOL_EN
    localparam int TOL_EFF = TOL;
`else
    // Exact dwell match: the tolerance window collapses to zero.
    localparam int TOL_EFF = 0 * TOL;
`endif

    function automatic logic [31:0] lo_bound(input int e);
        return (e - TOL_EFF < 1) ? 32'd1 : 32'(e - TOL_EFF);
    endfunction

    localparam logic [31:0] RED_LO   = lo_bound(RED_CYCLES);
    localparam logic [31:0] GREEN_LO = lo_bound(GREEN_CYCLES);
    localparam logic [31:0] BLUE_LO  = lo_bound(BLUE_CYCLES);
    localparam logic [31:0] RED_HI   = 32'(RED_CYCLES + TOL_EFF);
    localparam logic [31:0] GREEN_HI = 32'(GREEN_CYCLES + TOL_EFF);
    localparam logic [31:0] BLUE_HI  = 32'(BLUE_CYCLES + TOL_EFF);

    phase_t      phase_q;
    logic [2:0]  light_q;
    logic        cycle_ok;

    phase_t      code_ph;
    phase_t      succ;
    logic        ev;
    logic        illegal;
    logic        tracking;
    logic        under;
    logic        over;
    logic        bad_order;
    logic        seq_nx;
    logic        dur_nx;
    logic        code_nx;
    logic [31:0] lo_cur;
    logic [31:0] hi_cur;
    logic [31:0] dw32;

    assign phase = phase_q;

    always_comb begin
        ev       = (light != light_q);
        code_ph  = SYNC;
        lo_cur   = '0;
        hi_cur   = '0;
        succ     = RED;
        case (light)
            L_RED:   code_ph = RED;
            L_GREEN: code_ph = GREEN;
            L_BLUE:  code_ph = BLUE;
            default: code_ph = SYNC;
        endcase
        case (phase_q)
            RED:     begin lo_cur = RED_LO;   hi_cur = RED_HI;   succ = GREEN; end
            GREEN:   begin lo_cur = GREEN_LO; hi_cur = GREEN_HI; succ = BLUE;  end
            BLUE:    begin lo_cur = BLUE_LO;  hi_cur = BLUE_HI;  succ = RED;   end
            default: begin lo_cur = '0;       hi_cur = '0;       succ = RED;   end
        endcase
        // DARK is only a legal lamp state while we are still looking for RED.
        illegal   = (code_ph == SYNC) && !((light == L_DARK) && (phase_q == SYNC));
        tracking  = (phase_q != SYNC);
        dw32      = {24'd0, dwell};
        under     = (dw32 < lo_cur);
        // Fires on the step to HI+1 only; a saturated dwell can never step again.
        over      = (dw32 == hi_cur) && (dwell != 8'hFF);
        bad_order = (code_ph != succ);
        code_nx   = ev && illegal;
        dur_nx    = tracking && !code_nx && (ev ? under : over);
        seq_nx    = tracking && ev && !illegal && bad_order;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            light_q     <= L_DARK;
            phase_q     <= SYNC;
            dwell       <= '0;
            seq_err     <= 1'b0;
            dur_err     <= 1'b0;
            code_err    <= 1'b0;
            err_sticky  <= 1'b0;
            cycle_done  <= 1'b0;
            cycle_count <= '0;
            cycle_ok    <= 1'b0;
        end else begin
            light_q    <= light;
            dwell      <= ev ? 8'd1 : ((dwell == 8'hFF) ? dwell : dwell + 8'd1);
            seq_err    <= seq_nx;
            dur_err    <= dur_nx;
            code_err   <= code_nx;
            cycle_done <= 1'b0;

            if (seq_nx || dur_nx || code_nx)
                err_sticky <= 1'b1;
            else if (clr_err)
                err_sticky <= 1'b0;

            if (code_nx) begin
                phase_q  <= SYNC;
                cycle_ok <= 1'b0;
            end else if (ev && (code_ph == RED)) begin
                // Every RED entry re-arms; only a clean BLUE->RED closes a cycle.
                if ((phase_q == BLUE) && cycle_ok && !dur_nx && !seq_nx) begin
                    cycle_done <= 1'b1;
                    if (cycle_count != '1)
                        cycle_count <= cycle_count + CNT_W'(1);
                end
                phase_q  <= RED;
                cycle_ok <= 1'b1;
            end else if (tracking) begin
                if (seq_nx) begin
                    phase_q  <= SYNC;
                    cycle_ok <= 1'b0;
                end else begin
                    if (ev)
                        phase_q <= code_ph;
                    if (dur_nx)
                        cycle_ok <= 1'b0;
                end
            end
        end
    end

endmodule
